// File: rtl/instr_sequencer.sv
// Instruction fetch/issue sequencer: the producer side of the 4-bit opcode interface.
// It fetches a word from instruction memory at pc, latches it, and offers opcode and
// operand downstream over valid/ready. On acceptance it computes the next pc:
// jumps load the target, skips advance by 1 or 2, and a halt parks the sequencer.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             1-cycle pulse; runs from RESET_PC when idle or halted
//   imem_addr/rd_en   instruction memory address (= pc) and one-cycle read strobe
//   imem_rdata        read data, valid the cycle after imem_rd_en
//   issue_valid/ready issue handshake towards the control unit
//   opcode/operand    issued instruction fields
//   skip_cond         datapath condition, only looked at on a skip handshake
//   pc                address of the current/next instruction
//   halted            high while in the halted state
//   illegal           sticky illegal-opcode flag
//
// Build option: define SEQ_ILLEGAL_TRAP_EN to trap opcodes 7..15 (not issued, set
// illegal, halt at the offending pc). Without it those opcodes issue and act as NOP.
module instr_sequencer #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned INSTR_W  = 16,
   parameter int unsigned RESET_PC = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic               imem_rd_en,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               issue_valid,
   input  logic               issue_ready,
   output logic [3:0]         opcode,
   output logic [INSTR_W-5:0] operand,
   input  logic               skip_cond,
   output logic [ADDR_W-1:0]  pc,
   output logic               halted,
   output logic               illegal
);

   localparam int unsigned       OPC_W   = 4;
   localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);
   localparam logic [OPC_W-1:0]  OP_HALT = 4'd1;
   localparam logic [OPC_W-1:0]  OP_SKIP = 4'd5;
   localparam logic [OPC_W-1:0]  OP_JUMP = 4'd6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_ISSUE,
      S_HALTED
   } state_e;

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0]   ir_q, ir_d;
   logic                 rd_en_q, rd_en_d;
   logic                 valid_q, valid_d;
   logic                 halted_q, halted_d;
`ifdef SEQ_ILLEGAL_TRAP_EN
   logic                 illegal_q, illegal_d;
`endif

   // Next-state, next-pc and registered-output computation
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
`ifdef SEQ_ILLEGAL_TRAP_EN
      illegal_d = illegal_q;
`endif
      case (state_q)
         S_IDLE, S_HALTED: begin
            if (start) begin
               pc_d    = PC_RST;
               state_d = S_FETCH;
            end
         end
         S_FETCH: state_d = S_WAIT;
         S_WAIT: begin
            ir_d    = imem_rdata;
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
            // An illegal word never raised valid; trap one cycle after arriving here
            if (!valid_q) begin
               illegal_d = 1'b1;
               state_d   = S_HALTED;
            end else
`endif
            if (valid_q && issue_ready) begin
               state_d = S_FETCH;
               case (ir_q[INSTR_W-1 -: OPC_W])
                  OP_HALT: state_d = S_HALTED;
                  OP_SKIP: pc_d = skip_cond ? pc_q + ADDR_W'(2) : pc_q + ADDR_W'(1);
                  OP_JUMP: pc_d = ADDR_W'(ir_q[INSTR_W-5:0]);
                  default: pc_d = pc_q + ADDR_W'(1);
               endcase
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered, so they are derived from the state being entered
      rd_en_d  = (state_d == S_FETCH);
      halted_d = (state_d == S_HALTED);
`ifdef SEQ_ILLEGAL_TRAP_EN
      valid_d  = (state_d == S_ISSUE) && (ir_d[INSTR_W-1 -: OPC_W] <= OP_JUMP);
`else
      valid_d  = (state_d == S_ISSUE);
`endif
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         pc_q     <= PC_RST;
         ir_q     <= '0;
         rd_en_q  <= 1'b0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
`ifdef SEQ_ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         rd_en_q  <= rd_en_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
`ifdef SEQ_ILLEGAL_TRAP_EN
         illegal_q <= illegal_d;
`endif
      end
   end

   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign imem_rd_en  = rd_en_q;
   assign issue_valid = valid_q;
   assign halted      = halted_q;
   assign opcode      = ir_q[INSTR_W-1 -: OPC_W];
   assign operand     = ir_q[INSTR_W-5:0];
`ifdef SEQ_ILLEGAL_TRAP_EN
   assign illegal     = illegal_q;
`else
   assign illegal     = 1'b0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed programs plus random programs and handshakes,
// checked every cycle against a transaction-level model of fetch/issue/next-pc.
module tb_instr_sequencer;

   localparam int unsigned ADDR_W   = 8;
   localparam int unsigned INSTR_W  = 16;
   localparam int unsigned RESET_PC = 0;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start = 1'b0;
   logic                 issue_ready = 1'b0;
   logic                 skip_cond = 1'b0;
   logic [ADDR_W-1:0]    imem_addr, pc;
   logic                 imem_rd_en, issue_valid, halted, illegal;
   logic [INSTR_W-1:0]   imem_rdata;
   logic [3:0]           opcode;
   logic [INSTR_W-5:0]   operand;

   instr_sequencer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .imem_addr   (imem_addr),
      .imem_rd_en  (imem_rd_en),
      .imem_rdata  (imem_rdata),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .opcode      (opcode),
      .operand     (operand),
      .skip_cond   (skip_cond),
      .pc          (pc),
      .halted      (halted),
      .illegal     (illegal)
   );

   always #5 clk = ~clk;

   // Instruction memory with one cycle of read latency
   logic [15:0] mem [256];
   always @(posedge clk) if (imem_rd_en) imem_rdata <= mem[imem_addr];

   int n_vec = 0;
   int n_err = 0;
   int fetch_log[$];
   int issue_log[$];
   int stall_pc = -1;
   int stall_left = 0;

   // Model: what is in flight, where pc must be, and the flags
   bit         m_fetch, m_gap, m_valid, m_trap, m_halted, m_illegal;
   logic [7:0] m_pc;
   logic [15:0] m_word;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int qget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   function automatic bit legal(input logic [3:0] op);
`ifdef SEQ_ILLEGAL_TRAP_EN
      return op <= 4'd6;
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_reset();
      m_fetch = 0; m_gap = 0; m_valid = 0; m_trap = 0;
      m_halted = 0; m_illegal = 0;
      m_pc = 8'(RESET_PC);
      m_word = '0;
   endtask

   // One clock: compare at the falling edge, then drive inputs for the next rising edge
   task automatic step(input bit st, input bit rdy, input bit sk);
      bit r;
      bit busy;
      @(negedge clk);
      chk("rd_en", imem_rd_en, m_fetch);
      if (m_fetch) chk("fetch_addr", imem_addr, m_pc);
      chk("issue_valid", issue_valid, m_valid);
      if (m_valid) begin
         chk("opcode", opcode, m_word[15:12]);
         chk("operand", operand, m_word[11:0]);
         chk("issue_pc", pc, m_pc);
      end
      chk("halted", halted, m_halted);
      chk("illegal", illegal, m_illegal);

      r = rdy;
      if (issue_valid && stall_left > 0 && int'(pc) == stall_pc) begin
         r = 1'b0;
         stall_left--;
      end
      start = st; issue_ready = r; skip_cond = sk;
      if (imem_rd_en) fetch_log.push_back(int'(imem_addr));
      if (issue_valid && r) issue_log.push_back(int'(opcode));

      busy = m_fetch | m_gap | m_valid | m_trap;
      if (m_fetch) begin
         m_fetch = 0; m_gap = 1;
      end else if (m_gap) begin
         m_gap = 0;
         m_word = mem[m_pc];
         if (legal(m_word[15:12])) m_valid = 1; else m_trap = 1;
      end else if (m_trap) begin
         m_trap = 0; m_halted = 1; m_illegal = 1;
      end else if (m_valid && r) begin
         m_valid = 0;
         case (m_word[15:12])
            4'd1:    m_halted = 1;
            4'd5:    m_pc = m_pc + (sk ? 8'd2 : 8'd1);
            4'd6:    m_pc = m_word[7:0];
            default: m_pc = m_pc + 8'd1;
         endcase
         if (m_word[15:12] != 4'd1) m_fetch = 1;
      end
      if (!busy && st) begin
         m_pc = 8'(RESET_PC); m_fetch = 1; m_halted = 0;
      end
   endtask

   // Reset between clock edges; outputs must clear without any edge
   task automatic async_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", issue_valid, 0);
      chk("rst_rd_en", imem_rd_en, 0);
      chk("rst_pc", pc, RESET_PC);
      chk("rst_addr", imem_addr, RESET_PC);
      chk("rst_halted", halted, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_opcode", opcode, 0);
      model_reset();
      start = 0; issue_ready = 0; skip_cond = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic fill_halts();
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000;
   endtask

   task automatic run(input int n, input bit rdy, input bit sk);
      fetch_log.delete();
      issue_log.delete();
      step(1'b1, rdy, sk);
      for (int i = 1; i < n; i++) step(1'b0, rdy, sk);
   endtask

   initial begin
      model_reset();
      fill_halts();
      #12 rst_n = 1'b1;

      // Basic program: add, load, halt; then restart
      mem[0] = 16'h0000; mem[1] = 16'h2013; mem[2] = 16'h1000;
      async_reset();
      run(15, 1'b1, 1'b0);
      chk("t1_issued", issue_log.size(), 3);
      chk("t1_op0", qget(issue_log, 0), 0);
      chk("t1_op1", qget(issue_log, 1), 2);
      chk("t1_op2", qget(issue_log, 2), 1);
      chk("t1_halted", halted, 1);
      chk("t1_pc", pc, 2);
      chk("t1_fetches", fetch_log.size(), 3);
      run(4, 1'b1, 1'b0);
      chk("t1_refetch", qget(fetch_log, 0), 0);

      // Skip taken and not taken
      fill_halts();
      mem[0] = 16'h6003; mem[3] = 16'h5000;
      async_reset();
      run(15, 1'b1, 1'b1);
      chk("t2_taken", qget(fetch_log, 2), 5);
      run(15, 1'b1, 1'b0);
      chk("t2_not_taken", qget(fetch_log, 2), 4);

      // Jump with downstream stall
      fill_halts();
      mem[0] = 16'h6004; mem[4] = 16'h6020;
      async_reset();
      stall_pc = 4; stall_left = 3;
      run(20, 1'b1, 1'b0);
      chk("t3_stall_used", stall_left, 0);
      chk("t3_target", qget(fetch_log, 2), 32'h20);
      chk("t3_pc", pc, 32'h20);
      stall_pc = -1;

      // Wrap-around of pc arithmetic
      fill_halts();
      mem[0] = 16'h60FF; mem[8'hFF] = 16'h0000;
      async_reset();
      run(12, 1'b1, 1'b0);
      chk("t4_add_wrap", qget(fetch_log, 2), 0);
      fill_halts();
      mem[0] = 16'h60FE; mem[8'hFE] = 16'h5000;
      async_reset();
      run(12, 1'b1, 1'b1);
      chk("t4_skip_fe", qget(fetch_log, 2), 0);
      fill_halts();
      mem[0] = 16'h60FF; mem[8'hFF] = 16'h5000;
      async_reset();
      run(12, 1'b1, 1'b1);
      chk("t4_skip_ff", qget(fetch_log, 2), 1);
      fill_halts();
      mem[0] = 16'h6F80;
      async_reset();
      run(12, 1'b1, 1'b0);
      chk("t4_jump_trunc", pc, 32'h80);

      // Unassigned opcode 0xA at pc 7
      fill_halts();
      mem[0] = 16'h6007; mem[7] = 16'hA123;
      async_reset();
      run(15, 1'b1, 1'b0);
`ifdef SEQ_ILLEGAL_TRAP_EN
      chk("t5_fetches", fetch_log.size(), 2);
      chk("t5_illegal", illegal, 1);
      chk("t5_halted", halted, 1);
      chk("t5_pc", pc, 7);
`else
      chk("t5_next", qget(fetch_log, 2), 8);
      chk("t5_issued", qget(issue_log, 1), 32'hA);
      chk("t5_illegal", illegal, 0);
`endif

      // Reset while an issue is stalled
      fill_halts();
      mem[0] = 16'h2005;
      async_reset();
      stall_pc = 0; stall_left = 100;
      run(6, 1'b1, 1'b0);
      chk("t6_pending", issue_valid, 1);
      async_reset();
      stall_pc = -1; stall_left = 0;
      run(4, 1'b1, 1'b0);
      chk("t6_restart", qget(fetch_log, 0), RESET_PC);

      // Random programs, handshakes and restarts
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      async_reset();
      for (int c = 0; c < 4000; c++) begin
         if (c % 700 == 699) async_reset();
         step($urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0, 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
